ram_rr_arbiter: RTL and testbench
=================================

Name: ram_rr_arbiter

Overview:
- Two-client round-robin arbiter and sequencer for the single-port RAM (addr/rw/data_in/data_out; rw 0 = read, 1 = write).
- Sits between two requesters and the RAM. Serialises their accesses and drives the RAM port from registers.
- Returns read data to the owning client with a one-cycle valid pulse.

Parameters:
- AW, 3, address width (bits); matches the RAM.
- DW, 4, data width (bits); matches the RAM.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- req0  input  1  client 0 access request; held until gnt0 is seen.
- rw0  input  1  client 0 access type: 0 read, 1 write.
- addr0  input  AW  client 0 address.
- wdata0  input  DW  client 0 write data.
- gnt0  output  1  client 0 grant pulse.
- rvalid0  output  1  client 0 read-data-valid pulse.
- rdata0  output  DW  client 0 read data.
- req1, rw1, addr1, wdata1, gnt1, rvalid1, rdata1: same as client 0, for client 1.
- ram_addr  output  AW  RAM address.
- ram_rw  output  1  RAM rw.
- ram_data_in  output  DW  RAM write data.
- ram_data_out  input  DW  RAM read data; registered inside the RAM, valid the cycle after the read edge.

Behaviour:
- Reset (reset=0, asynchronous), all cleared immediately:
  - state=IDLE, last=1 (client 0 wins the first tie).
  - gnt0/1=0, rvalid0/1=0, rdata0/1=0.
  - ram_addr=0, ram_rw=0, ram_data_in=0.
  - An in-flight read is dropped; no rvalid follows reset release.
- All outputs are registered; no combinational path from inputs to outputs.
- ram_rw is 1 only in ACCESS cycles of a write grant, so no spurious writes occur.
- FSM states: IDLE, ACCESS, RWAIT.
- IDLE:
  - Sample req0/req1 at the edge.
  - If neither is set, stay in IDLE, ram_rw=0, ram_addr/ram_data_in hold.
  - If exactly one is set, grant it. If both are set, grant the client != last.
  - On the grant edge:
    - ram_addr/ram_rw/ram_data_in <= winner's addr/rw/wdata.
    - gntX <= 1 and last <= X.
    - owner <= X; rd <= rwX==0.
    - state <= ACCESS.
- ACCESS (exactly 1 cycle):
  - gntX is high for this whole cycle only.
  - The RAM performs the write, or registers the read, at the edge ending ACCESS.
  - At that edge: gntX <= 0 and ram_rw <= 0.
  - If the grant was a write, state <= IDLE. If a read, state <= RWAIT.
- RWAIT (exactly 1 cycle):
  - At the edge ending RWAIT, rdata[owner] <= ram_data_out, rvalid[owner] <= 1, state <= IDLE.
  - rvalid is high for the following cycle only; rdata holds until that client's next read.
  - The non-owner's rdata is untouched.
- Latency:
  - Write: grant edge to RAM write = 1 edge. Minimum spacing between grants = 2 cycles.
  - Read: rvalid is high in the 3rd cycle after the grant edge (grant, ACCESS, RWAIT, then rvalid cycle). Minimum spacing between grants = 3 cycles.
  - rvalid overlaps the next IDLE decision cycle, so the next grant can occur at the same edge that drops rvalid.
- Client handshake:
  - req/rw/addr/wdata must stay stable from req assertion until the edge ending the gnt cycle.
  - The client must drop req, or present a new request, at that edge.
  - req still high in IDLE is a new request.
- Fairness:
  - With both clients continuously requesting, grants strictly alternate 0,1,0,1.
  - A single requester is granted every access slot regardless of last.
- Boundary behaviour:
  - A request rising during ACCESS/RWAIT is ignored until IDLE; there is no queueing beyond the req level.
  - req dropped before grant means the access is never performed; this is legal.
  - Address wraps naturally at 2^AW-1; no special handling.
  - Reset asserted mid-ACCESS of a write: whether the RAM write happens depends only on the RAM. The arbiter drives ram_rw=0 immediately.

Test Plan:
- Reset: hold reset=0 for 2 edges with req0=req1=1 -> all outputs 0 and no gnt. After release, first gnt is gnt0 (tie, last=1).
- Single writes then reads, client 0: write data 1..8 to addr 0..7, then read addr 0..7 -> each gnt0 is a 1-cycle pulse; ram_rw=1 only in ACCESS. rvalid0 pulses 3 cycles after each grant with rdata0=1..8; rvalid1 stays 0.
- Contention: req0 and req1 both held continuously; client 0 writes 0xA to addr 2, client 1 reads addr 2 -> grants alternate gnt0, gnt1. Client 1 gets rdata1=0xA once the client-0 write precedes it.
- Routing: client 1 writes 0x5 to addr 7, then client 0 reads addr 7 -> rvalid0=1 with rdata0=0x5; rdata1 unchanged; rvalid1 stays 0.
- Mid-read reset: assert reset during RWAIT -> rvalid0/1 never assert. After release, FSM is in IDLE and ram_rw=0.
- Withdrawn request: req1 pulsed high for 1 cycle while a client-0 read is in RWAIT -> no gnt1, no RAM access for client 1.

Source files
------------

// File: rtl/ram_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ram_rr_arbiter                                                  |
// | Purpose  : Two-client round-robin arbiter/sequencer for a single-port RAM. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ram_rr_arbiter #(
    parameter int AW = 3,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          rw0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          rw1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rw,
    output logic [DW-1:0] ram_data_in,
    input  logic [DW-1:0] ram_data_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RWAIT  = 2'd2
    } state_t;

    state_t        r_state, w_state;
    logic          r_last, w_last;
    logic          r_owner, w_owner;
    logic          r_rd, w_rd;
    logic          r_gnt0, w_gnt0, r_gnt1, w_gnt1;
    logic          r_rvalid0, w_rvalid0, r_rvalid1, w_rvalid1;
    logic [DW-1:0] r_rdata0, w_rdata0, r_rdata1, w_rdata1;
    logic [AW-1:0] r_ram_addr, w_ram_addr;
    logic          r_ram_rw, w_ram_rw;
    logic [DW-1:0] r_ram_data_in, w_ram_data_in;
    logic          w_pick1;

    // Client 1 wins when it is the only requester, or on a tie when client 0 went last.
    assign w_pick1 = req1 & (~req0 | ~r_last);

    always_comb begin
        w_state       = r_state;
        w_last        = r_last;
        w_owner       = r_owner;
        w_rd          = r_rd;
        w_gnt0        = 1'b0;
        w_gnt1        = 1'b0;
        w_rvalid0     = 1'b0;
        w_rvalid1     = 1'b0;
        w_rdata0      = r_rdata0;
        w_rdata1      = r_rdata1;
        w_ram_addr    = r_ram_addr;
        w_ram_rw      = 1'b0;
        w_ram_data_in = r_ram_data_in;
        case (r_state)
            S_IDLE: begin
                if (req0 | req1) begin
                    w_state = S_ACCESS;
                    if (w_pick1) begin
                        w_ram_addr    = addr1;
                        w_ram_rw      = rw1;
                        w_ram_data_in = wdata1;
                        w_gnt1        = 1'b1;
                        w_last        = 1'b1;
                        w_owner       = 1'b1;
                        w_rd          = ~rw1;
                    end else begin
                        w_ram_addr    = addr0;
                        w_ram_rw      = rw0;
                        w_ram_data_in = wdata0;
                        w_gnt0        = 1'b1;
                        w_last        = 1'b0;
                        w_owner       = 1'b0;
                        w_rd          = ~rw0;
                    end
                end
            end
            S_ACCESS: w_state = r_rd ? S_RWAIT : S_IDLE;
            S_RWAIT: begin
                // RAM output is valid in this cycle; route it to the owning client only.
                if (r_owner) begin
                    w_rdata1  = ram_data_out;
                    w_rvalid1 = 1'b1;
                end else begin
                    w_rdata0  = ram_data_out;
                    w_rvalid0 = 1'b1;
                end
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_last        <= 1'b1;
            r_owner       <= 1'b0;
            r_rd          <= 1'b0;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_rvalid0     <= 1'b0;
            r_rvalid1     <= 1'b0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
            r_ram_addr    <= '0;
            r_ram_rw      <= 1'b0;
            r_ram_data_in <= '0;
        end else begin
            r_state       <= w_state;
            r_last        <= w_last;
            r_owner       <= w_owner;
            r_rd          <= w_rd;
            r_gnt0        <= w_gnt0;
            r_gnt1        <= w_gnt1;
            r_rvalid0     <= w_rvalid0;
            r_rvalid1     <= w_rvalid1;
            r_rdata0      <= w_rdata0;
            r_rdata1      <= w_rdata1;
            r_ram_addr    <= w_ram_addr;
            r_ram_rw      <= w_ram_rw;
            r_ram_data_in <= w_ram_data_in;
        end
    end

    assign gnt0        = r_gnt0;
    assign gnt1        = r_gnt1;
    assign rvalid0     = r_rvalid0;
    assign rvalid1     = r_rvalid1;
    assign rdata0      = r_rdata0;
    assign rdata1      = r_rdata1;
    assign ram_addr    = r_ram_addr;
    assign ram_rw      = r_ram_rw;
    assign ram_data_in = r_ram_data_in;

endmodule
`default_nettype wire

// File: tb/tb_ram_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ram_rr_arbiter                                               |
// | Purpose  : Directed, table-driven bench for ram_rr_arbiter with a RAM model.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ram_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, rw0, req1, rw1;
    logic [2:0] addr0, addr1;
    logic [3:0] wdata0, wdata1;
    logic       gnt0, rvalid0, gnt1, rvalid1;
    logic [3:0] rdata0, rdata1;
    logic [2:0] ram_addr;
    logic       ram_rw;
    logic [3:0] ram_data_in;
    logic [3:0] ram_data_out = 4'd0;
    logic [3:0] mem [8];

    int n_err = 0;
    int n_chk = 0;
    logic [3:0] exp_rdata [2];

    typedef struct {
        logic       client;
        logic       rw;
        logic [2:0] addr;
        logic [3:0] wdata;
        logic [3:0] exp_rdata;
    } vec_t;

    vec_t vecs [18];

    always #5 clk = ~clk;

    // Single-port RAM model: write on edge, registered read.
    always @(posedge clk) begin
        if (ram_rw) mem[ram_addr] <= ram_data_in;
        ram_data_out <= mem[ram_addr];
    end

    ram_rr_arbiter #(.AW(3), .DW(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_rw(ram_rw), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " gnt0"}, int'(gnt0), 0);
        chk({tag, " gnt1"}, int'(gnt1), 0);
        chk({tag, " rvalid0"}, int'(rvalid0), 0);
        chk({tag, " rvalid1"}, int'(rvalid1), 0);
        chk({tag, " ram_rw"}, int'(ram_rw), 0);
    endtask

    // One transaction from an idle arbiter: request, grant, optional read return.
    task automatic run_txn(input vec_t v);
        if (v.client) begin
            req1 = 1'b1; rw1 = v.rw; addr1 = v.addr; wdata1 = v.wdata;
        end else begin
            req0 = 1'b1; rw0 = v.rw; addr0 = v.addr; wdata0 = v.wdata;
        end
        step();
        chk("txn gnt0", int'(gnt0), v.client ? 0 : 1);
        chk("txn gnt1", int'(gnt1), v.client ? 1 : 0);
        chk("txn ram_rw", int'(ram_rw), int'(v.rw));
        chk("txn ram_addr", int'(ram_addr), int'(v.addr));
        if (v.rw) chk("txn ram_data_in", int'(ram_data_in), int'(v.wdata));
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        chk_quiet("txn post");
        if (!v.rw) begin
            step();
            exp_rdata[v.client] = v.exp_rdata;
            chk("rd rvalid0", int'(rvalid0), v.client ? 0 : 1);
            chk("rd rvalid1", int'(rvalid1), v.client ? 1 : 0);
            chk("rd rdata0", int'(rdata0), int'(exp_rdata[0]));
            chk("rd rdata1", int'(rdata1), int'(exp_rdata[1]));
            chk("rd ram_rw", int'(ram_rw), 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            vecs[i]     = '{1'b0, 1'b1, 3'(i), 4'(i + 1), 4'd0};
            vecs[i + 8] = '{1'b0, 1'b0, 3'(i), 4'd0, 4'(i + 1)};
        end
        vecs[16] = '{1'b1, 1'b1, 3'd7, 4'h5, 4'd0};
        vecs[17] = '{1'b0, 1'b0, 3'd7, 4'd0, 4'h5};
        exp_rdata[0] = 4'd0;
        exp_rdata[1] = 4'd0;

        // Reset held with both clients requesting.
        reset = 1'b0;
        req0 = 1'b1; rw0 = 1'b0; addr0 = 3'd0; wdata0 = 4'd0;
        req1 = 1'b1; rw1 = 1'b0; addr1 = 3'd0; wdata1 = 4'd0;
        repeat (2) step();
        chk_quiet("rst");
        chk("rst rdata0", int'(rdata0), 0);
        chk("rst rdata1", int'(rdata1), 0);
        chk("rst ram_addr", int'(ram_addr), 0);
        chk("rst ram_data_in", int'(ram_data_in), 0);

        // First tie after reset goes to client 0.
        reset = 1'b1;
        rw0 = 1'b1; addr0 = 3'd0; wdata0 = 4'd1;
        rw1 = 1'b1; addr1 = 3'd3; wdata1 = 4'd4;
        step();
        chk("tie gnt0", int'(gnt0), 1);
        chk("tie gnt1", int'(gnt1), 0);
        chk("tie ram_rw", int'(ram_rw), 1);
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        chk_quiet("tie post");
        step();
        chk("withdrawn after tie gnt1", int'(gnt1), 0);

        for (int i = 0; i < 18; i++) run_txn(vecs[i]);

        // Contention: last grant was client 0, so client 1 goes first.
        begin
            int g_seq [$];
            int rv_cnt = 0;
            req0 = 1'b1; rw0 = 1'b1; addr0 = 3'd2; wdata0 = 4'hA;
            req1 = 1'b1; rw1 = 1'b0; addr1 = 3'd2; wdata1 = 4'd0;
            for (int c = 0; c < 9; c++) begin
                step();
                if (gnt0 && gnt1) chk("both gnt", 1, 0);
                if (gnt0) g_seq.push_back(0);
                if (gnt1) g_seq.push_back(1);
                if (gnt0 || gnt1) chk("cont ram_rw", int'(ram_rw), gnt0 ? 1 : 0);
                if (rvalid1) begin
                    chk("cont rdata1", int'(rdata1), rv_cnt == 0 ? 3 : 'hA);
                    rv_cnt++;
                end
                chk("cont rvalid0", int'(rvalid0), 0);
            end
            req0 = 1'b0;
            req1 = 1'b0;
            chk("cont grant count", g_seq.size(), 4);
            chk("cont rvalid1 count", rv_cnt, 2);
            if (g_seq.size() == 4) begin
                chk("cont g0", g_seq[0], 1);
                chk("cont g1", g_seq[1], 0);
                chk("cont g2", g_seq[2], 1);
                chk("cont g3", g_seq[3], 0);
            end
            step();
            step();
            chk_quiet("cont post");
            exp_rdata[1] = 4'hA;
        end

        // Reset during RWAIT drops the read.
        req0 = 1'b1; rw0 = 1'b0; addr0 = 3'd2;
        step();
        chk("mr gnt0", int'(gnt0), 1);
        req0 = 1'b0;
        step();
        reset = 1'b0;
        #1;
        chk_quiet("mr in reset");
        chk("mr rdata0", int'(rdata0), 0);
        chk("mr rdata1", int'(rdata1), 0);
        step();
        reset = 1'b1;
        exp_rdata[0] = 4'd0;
        exp_rdata[1] = 4'd0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_quiet("mr after");
        end

        // Client 1 pulses req only while client 0's read is in RWAIT.
        req0 = 1'b1; rw0 = 1'b0; addr0 = 3'd5;
        step();
        chk("wd gnt0", int'(gnt0), 1);
        req0 = 1'b0;
        step();
        req1 = 1'b1; rw1 = 1'b1; addr1 = 3'd5; wdata1 = 4'hF;
        step();
        req1 = 1'b0;
        chk("wd rvalid0", int'(rvalid0), 1);
        chk("wd rdata0", int'(rdata0), 6);
        chk("wd gnt1", int'(gnt1), 0);
        chk("wd rdata1", int'(rdata1), int'(exp_rdata[1]));
        for (int c = 0; c < 3; c++) begin
            step();
            chk_quiet("wd after");
        end
        chk("wd mem untouched", int'(mem[5]), 6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
